mse_gpio_port: RTL and testbench

//  - Grid-bus slave register block owning one 8-bit bidirectional IO port of the MSE fabric.
//  - Sits between the grid bus (clk/address/data/wr/rd) and a single portN pin group.
//  - Replaces free-running port drive with per-bit direction, output latch, synchronised input

---
 rtl/mse_gpio_port.sv | 122 ++++++++++++
 tb/tb_mse_gpio_port.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mse_gpio_port.sv
// mse_gpio_port: grid-bus slave owning one 8-bit bidirectional IO port.
// Define GPIO_IRQ_EN to build rising-edge capture, EDGE_FLAGS/EDGE_MASK and irq.
module mse_gpio_port #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter logic [7:0] RESET_OUT = 8'h00,
  parameter logic [7:0] RESET_DIR = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  address,
  inout  wire  [15:0] data,
  input  logic        wr,
  input  logic        rd,
  inout  wire  [7:0]  port,
  output logic        irq
);

  localparam logic [2:0] OFF_OUT = 3'd0;
  localparam logic [2:0] OFF_DIR = 3'd1;
  localparam logic [2:0] OFF_PIN = 3'd2;

  logic       hit;
  logic [2:0] offset;
  logic       wr_q;
  logic       wr_commit;
  logic [7:0] wr_byte;
  logic [7:0] data_out;
  logic [7:0] dir;
  logic [7:0] pin_sync_p0;
  logic [7:0] pin_sync_p1;
  logic [7:0] rd_byte;
  logic       unused_data_hi;

  assign hit            = (address[7:3] == BASE_ADDR[7:3]);
  assign offset         = address[2:0];
  assign wr_byte        = data[7:0];
  assign unused_data_hi = ^data[15:8];

  // A held strobe commits once: only the cycle where wr rises writes.
  assign wr_commit = hit & wr & ~wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
    end else if (wr_commit) begin
      if (offset == OFF_OUT) data_out <= wr_byte;
      if (offset == OFF_DIR) dir      <= wr_byte;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_pin
    assign port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  // Stage p0 -> p1: two-flop synchroniser on the pins; p1 is PIN_IN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_sync_p0 <= 8'h00;
      pin_sync_p1 <= 8'h00;
    end else begin
      pin_sync_p0 <= port;
      pin_sync_p1 <= pin_sync_p0;
    end
  end

`ifdef GPIO_IRQ_EN
  localparam logic [2:0] OFF_FLAGS = 3'd3;
  localparam logic [2:0] OFF_MASK  = 3'd4;

  logic [7:0] pin_prev_p2;
  logic [7:0] edge_flags;
  logic [7:0] edge_mask;
  logic [7:0] rise;
  logic [7:0] w1c;

  assign rise = pin_sync_p1 & ~pin_prev_p2;
  assign w1c  = (wr_commit && (offset == OFF_FLAGS)) ? wr_byte : 8'h00;

  // Stage p1 -> p2: previous synchronised value; a new rise beats a same-edge clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_prev_p2 <= 8'h00;
      edge_flags  <= 8'h00;
      edge_mask   <= 8'h00;
    end else begin
      pin_prev_p2 <= pin_sync_p1;
      edge_flags  <= (edge_flags & ~w1c) | rise;
      if (wr_commit && (offset == OFF_MASK)) edge_mask <= wr_byte;
    end
  end

  assign irq = |(edge_flags & edge_mask);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_byte = 8'h00;
    case (offset)
      OFF_OUT:   rd_byte = data_out;
      OFF_DIR:   rd_byte = dir;
      OFF_PIN:   rd_byte = pin_sync_p1;
`ifdef GPIO_IRQ_EN
      OFF_FLAGS: rd_byte = edge_flags;
      OFF_MASK:  rd_byte = edge_mask;
`endif
      default:   rd_byte = 8'h00;
    endcase
  end

  assign data = (rd && hit) ? {8'h00, rd_byte} : 16'hzzzz;

endmodule

// File: tb/tb_mse_gpio_port.sv
// Bench for mse_gpio_port: bus pulled up and pins pulled down so a released
// line reads as a known level; a sample-history model predicts every output.
`timescale 1ns/1ps
module tb_mse_gpio_port;

  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        drv_en = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic [7:0]  ext_en = 8'h00;
  logic [7:0]  ext_val = 8'h00;
  wire  [15:0] data;
  wire  [7:0]  port;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  assign data = drv_en ? wdata : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data[i]);
  end
  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign port[i] = ext_en[i] ? ext_val[i] : 1'bz;
    pulldown (port[i]);
  end

  mse_gpio_port #(.BASE_ADDR(BASE), .RESET_OUT(8'h00), .RESET_DIR(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .data(data),
    .wr(wr), .rd(rd), .port(port), .irq(irq)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: registers plus history of pin samples (hist[0] = latest edge)
  logic [7:0] m_out, m_dir, m_flags, m_mask;
  logic       m_wrq;
  logic [7:0] hist [4];

  function automatic logic m_hit(input logic [7:0] a);
    return a[7:3] == BASE[7:3];
  endfunction

  function automatic logic [7:0] m_pins();
    return (m_dir & m_out) | (~m_dir & ext_en & ext_val);
  endfunction

  function automatic logic [7:0] m_reg(input logic [2:0] off);
    case (off)
      3'd0: return m_out;
      3'd1: return m_dir;
      3'd2: return hist[1];
`ifdef GPIO_IRQ_EN
      3'd3: return m_flags;
      3'd4: return m_mask;
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_out = 8'h00; m_dir = 8'h00; m_flags = 8'h00; m_mask = 8'h00; m_wrq = 1'b0;
    for (int k = 0; k < 4; k++) hist[k] = 8'h00;
  endtask

  task automatic m_step();
    logic [7:0] pins, rise, w1c;
    logic       commit;
    if (!reset_n) begin
      m_reset();
      return;
    end
    pins   = m_pins();
    commit = wr && !m_wrq && m_hit(address);
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = pins;
    rise = hist[2] & ~hist[3];
    w1c  = (commit && address[2:0] == 3'd3) ? wdata[7:0] : 8'h00;
`ifdef GPIO_IRQ_EN
    m_flags = (m_flags & ~w1c) | rise;
    if (commit && address[2:0] == 3'd4) m_mask = wdata[7:0];
`else
    if (w1c != rise) m_flags = 8'h00;
`endif
    if (commit && address[2:0] == 3'd0) m_out = wdata[7:0];
    if (commit && address[2:0] == 3'd1) m_dir = wdata[7:0];
    m_wrq = wr;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm);
    chk({nm, ".port"}, {8'h00, port}, {8'h00, m_pins()});
    chk({nm, ".irq"}, {15'h0, irq}, {15'h0, |(m_flags & m_mask)});
    if (!drv_en)
      chk({nm, ".data"}, data,
          (rd && m_hit(address)) ? {8'h00, m_reg(address[2:0])} : 16'hFFFF);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic step(input string nm);
    #1;
    check_all(nm);
    tick();
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
    address = a; wdata = d; wr = 1'b1; drv_en = 1'b1; rd = 1'b0;
    step("wr");
    wr = 1'b0; drv_en = 1'b0;
    step("wr_idle");
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [15:0] exp);
    address = a; rd = 1'b1;
    #1;
    chk(nm, data, exp);
    rd = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  waddr;
    logic [15:0] wd;
    logic [7:0]  raddr;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    m_reset();
    vt[0] = '{8'h11, 16'hFF0F, 8'h11, 16'h000F};
    vt[1] = '{8'h10, 16'h00A5, 8'h10, 16'h00A5};
    vt[2] = '{8'h15, 16'h00FF, 8'h15, 16'h0000};
    vt[3] = '{8'h17, 16'h0033, 8'h17, 16'h0000};
    vt[4] = '{8'h12, 16'h00FF, 8'h12, 16'h0005};
`ifdef GPIO_IRQ_EN
    vt[5] = '{8'h14, 16'h0080, 8'h14, 16'h0080};
`else
    vt[5] = '{8'h14, 16'h0080, 8'h14, 16'h0000};
`endif
    vt[6] = '{8'h13, 16'h00FF, 8'h13, 16'h0000};
    vt[7] = '{8'h20, 16'h0011, 8'h20, 16'hFFFF};
    vt[8] = '{8'h08, 16'h0000, 8'h10, 16'h00A5};
    vt[9] = '{8'h10, 16'h005A, 8'h10, 16'h005A};

    // Reset state
    tick(); tick();
    #1;
    chk("rst.port", {8'h00, port}, 16'h0000);
    chk("rst.irq", {15'h0, irq}, 16'h0000);
    rd_chk("rst.rd10", 8'h10, 16'h0000);
    rd_chk("rst.rd11", 8'h11, 16'h0000);
    rd_chk("rst.rd20", 8'h20, 16'hFFFF);
    reset_n = 1'b1;
    step("rel");

    // Register map vectors
    for (int v = 0; v < 10; v++) begin
      bus_wr(vt[v].waddr, vt[v].wd);
      if (v == 1) chk("vec.port05", {8'h00, port}, 16'h0005);
      rd_chk($sformatf("vec%0d", v), vt[v].raddr, vt[v].exp);
      step("vec_idle");
    end
    chk("vec.port0A", {8'h00, port}, 16'h000A);
    bus_wr(8'h10, 16'h00FF);
    chk("hiz.upper", {8'h00, port}, 16'h000F);

    // Held strobe commits once, with first-cycle data
    address = 8'h10; wdata = 16'h0011; wr = 1'b1; drv_en = 1'b1;
    step("hold");
    wdata = 16'h0022;
    for (int k = 0; k < 4; k++) step("hold");
    wr = 1'b0; drv_en = 1'b0;
    step("hold_end");
    rd_chk("hold.single", 8'h10, 16'h0011);

    // PIN_IN latency: two edges, not one
    bus_wr(8'h10, 16'h0005);
    for (int k = 0; k < 4; k++) step("settle");
    ext_en = 8'hF0; ext_val = 8'hC0; rd = 1'b1; address = 8'h12;
    step("pin.e1");
    #1 chk("pin.after1", data, 16'h0005);
    step("pin.e2");
    #1 chk("pin.after2", data, 16'h00C5);
    rd = 1'b0;
    ext_en = 8'h00;
    for (int k = 0; k < 4; k++) step("settle");

`ifdef GPIO_IRQ_EN
    bus_wr(8'h13, 16'h00FF);
    chk("irq.clear0", {15'h0, irq}, 16'h0000);
    ext_en = 8'h80; ext_val = 8'h80;
    step("irq.e1");
    step("irq.e2");
    #1 chk("irq.before3", {15'h0, irq}, 16'h0000);
    step("irq.e3");
    chk("irq.on3", {15'h0, irq}, 16'h0001);
    rd_chk("irq.flags80", 8'h13, 16'h0080);
    address = 8'h13; wdata = 16'h0080; wr = 1'b1; drv_en = 1'b1;
    step("irq.w1c");
    wr = 1'b0; drv_en = 1'b0;
    #1 chk("irq.cleared", {15'h0, irq}, 16'h0000);
    rd_chk("irq.flags0", 8'h13, 16'h0000);
    ext_val = 8'h00;
    for (int k = 0; k < 4; k++) step("irq.low");
    ext_val = 8'h80;
    step("race.e1");
    step("race.e2");
    address = 8'h13; wdata = 16'h0080; wr = 1'b1; drv_en = 1'b1;
    step("race.e3");
    wr = 1'b0; drv_en = 1'b0;
    #1 chk("race.irq", {15'h0, irq}, 16'h0001);
    rd_chk("race.flag", 8'h13, 16'h0080);
    step("race.after");
    bus_wr(8'h13, 16'h00FF);
    ext_en = 8'h00;
`else
    ext_en = 8'h80; ext_val = 8'h80;
    for (int k = 0; k < 5; k++) step("noirq");
    chk("noirq.irq", {15'h0, irq}, 16'h0000);
    rd_chk("noirq.rd13", 8'h13, 16'h0000);
    ext_en = 8'h00;
`endif
    for (int k = 0; k < 4; k++) step("settle");

    // Asynchronous reset mid-write with all pins driven
    bus_wr(8'h11, 16'h00FF);
    bus_wr(8'h10, 16'h00FF);
    chk("pre_rst.port", {8'h00, port}, 16'h00FF);
    address = 8'h10; wdata = 16'h0000; wr = 1'b1; drv_en = 1'b1;
    #2 reset_n = 1'b0;
    #1 m_reset();
    chk("arst.port", {8'h00, port}, 16'h0000);
    chk("arst.irq", {15'h0, irq}, 16'h0000);
    wr = 1'b0; drv_en = 1'b0;
    ext_en = 8'h08; ext_val = 8'h08;
    rd_chk("arst.dir", 8'h11, 16'h0000);
    rd_chk("arst.out", 8'h10, 16'h0000);
    tick(); tick();
    #3 reset_n = 1'b1;
    for (int k = 0; k < 6; k++) step("post_rst");
    rd_chk("post_rst.pin", 8'h12, 16'h0008);
`ifdef GPIO_IRQ_EN
    rd_chk("post_rst.flag3", 8'h13, 16'h0008);
    bus_wr(8'h13, 16'h00FF);
    for (int k = 0; k < 5; k++) step("post_rst2");
    rd_chk("post_rst.once", 8'h13, 16'h0000);
`endif
    ext_en = 8'h00;
    step("idle");

    // Randomised traffic against the model
    for (int c = 0; c < 500; c++) begin
      logic [7:0] hi;
      logic [7:0] dmask;
      hi      = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE;
      address = {hi[7:3], 3'($urandom_range(0, 7))};
      wr      = ($urandom_range(0, 2) == 0);
      rd      = !wr && $urandom_range(0, 1) == 1;
      drv_en  = wr;
      wdata   = 16'($urandom);
      dmask   = (wr && m_hit(address) && address[2:0] == 3'd1) ? wdata[7:0] : 8'h00;
      ext_val = 8'($urandom);
      ext_en  = 8'($urandom) & ~m_dir & ~dmask;
      step("rnd");
    end
    wr = 1'b0; rd = 1'b0; drv_en = 1'b0; ext_en = 8'h00;
    step("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
